// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// load/store width codes, split-access state encoding and the byte-mask helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        S_IDLE,
        S_SPLIT2
    } state_t;

    // Unshifted byte-lane mask for an access width; unknown codes act as a word.
    function automatic logic [3:0] width_mask(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: width_mask = 4'b0001;
            F3_H, F3_HU: width_mask = 4'b0011;
            F3_W:        width_mask = 4'b1111;
            default:     width_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load formatter: shifts the (possibly two-word) merge word down by the byte
// offset and sign- or zero-extends the selected byte/halfword.
module lsu_load_align
    import dmem_pkg::*;
(
    input  logic [63:0] merge_word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] word;

    assign word = 32'(merge_word >> {off, 3'b000});

    // Extend the low byte/halfword according to the width code.
    always_comb begin
        case (funct3)
            F3_B:    result = {{24{word[7]}}, word[7:0]};
            F3_H:    result = {{16{word[15]}}, word[15:0]};
            F3_BU:   result = {24'b0, word[7:0]};
            F3_HU:   result = {16'b0, word[15:0]};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory port. Drives a synchronous-read BRAM, splits
// word-crossing accesses into two word accesses (one stall cycle) and
// returns formatted load data in the WB stage.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall_out,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              misalign_err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    output logic [3:0]        dm_be,
    input  logic [31:0]       dm_rdata
);

    // Request decode
    logic [1:0]        req_off;
    logic [ADDR_W-1:0] req_word;
    logic [7:0]        req_m8;
    logic [63:0]       req_sd64;
    logic              req_active;
    logic              req_is_load;
    logic              req_cross;
    logic              unused_addr_bits;

    assign req_off          = req_addr[1:0];
    assign req_word         = req_addr[ADDR_W+1:2];
    assign req_m8           = {4'b0000, width_mask(req_funct3)} << req_off;
    assign req_sd64         = {32'b0, req_wdata} << {req_off, 3'b000};
    assign req_active       = req_load | req_store;
    assign req_is_load      = req_load & ~req_store;
    assign req_cross        = req_active & (|req_m8[7:4]);
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    // Split-access state and registered second-word copy
    state_t            state, next_state;
    logic [ADDR_W-1:0] split_word;
    logic [1:0]        split_off;
    logic [2:0]        split_f3;
    logic              split_load;
    logic              split_store;
    logic [3:0]        split_be;
    logic [31:0]       split_wdata;
    logic [31:0]       lo_reg;

    // WB-stage load tracking
    logic              wb_valid;
    logic              wb_split;
    logic [1:0]        wb_off;
    logic [2:0]        wb_f3;
    logic              issue_load;

    // Next-state and BRAM drive; reset forces the port quiet so a pending
    // second write is dropped in the same cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        next_state   = state;
        dm_addr      = req_word;
        dm_be        = 4'b0000;
        dm_wdata     = 32'b0;
        stall_out    = 1'b0;
        misalign_err = 1'b0;
        issue_load   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_active) begin
                    dm_wdata = req_sd64[31:0];
                    if (req_store) dm_be = req_m8[3:0];
                    if (req_cross && SPLIT_EN) begin
                        stall_out  = 1'b1;
                        next_state = S_SPLIT2;
                    end else begin
                        misalign_err = req_cross;
                        issue_load   = req_is_load;
                    end
                end
            end
            S_SPLIT2: begin
                dm_addr    = split_word;
                dm_be      = split_store ? split_be : 4'b0000;
                dm_wdata   = split_wdata;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        if (!nrst) begin
            next_state   = S_IDLE;
            dm_addr      = '0;
            dm_be        = 4'b0000;
            dm_wdata     = 32'b0;
            stall_out    = 1'b0;
            misalign_err = 1'b0;
            issue_load   = 1'b0;
        end
    end

    // State, split metadata, low-word capture and WB tracking registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!nrst) begin
            // NOTE: lo_reg and the split copy are plain flops, so they are reset along with the state.
            state       <= S_IDLE;
            split_word  <= '0;
            split_off   <= 2'b00;
            split_f3    <= 3'b000;
            split_load  <= 1'b0;
            split_store <= 1'b0;
            split_be    <= 4'b0000;
            split_wdata <= 32'b0;
            lo_reg      <= 32'b0;
            wb_valid    <= 1'b0;
            wb_split    <= 1'b0;
            wb_off      <= 2'b00;
            wb_f3       <= 3'b000;
        end else begin
            state <= next_state;
            if (state == S_IDLE && next_state == S_SPLIT2) begin
                split_word  <= req_word + ADDR_W'(1);
                split_off   <= req_off;
                split_f3    <= req_funct3;
                split_load  <= req_is_load;
                split_store <= req_store;
                split_be    <= req_m8[7:4];
                split_wdata <= req_sd64[63:32];
            end
            if (state == S_SPLIT2) lo_reg <= dm_rdata;
            wb_valid <= issue_load | (state == S_SPLIT2 && split_load);
            wb_split <= (state == S_SPLIT2);
            wb_off   <= (state == S_SPLIT2) ? split_off : req_off;
            wb_f3    <= (state == S_SPLIT2) ? split_f3 : req_funct3;
        end
    end

    logic [63:0] merge_word;
    logic [31:0] aligned;

    assign merge_word = wb_split ? {dm_rdata, lo_reg} : {32'b0, dm_rdata};

    lsu_load_align u_align (
        .merge_word (merge_word),
        .off        (wb_off),
        .funct3     (wb_f3),
        .result     (aligned)
    );

    assign load_valid = wb_valid & nrst;
    assign load_data  = load_valid ? aligned : 32'b0;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: split and non-split instances, each
// with its own synchronous-read byte-enable BRAM model.
module tb_dmem_access_unit;
    import dmem_pkg::*;

    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Split-enabled instance
    logic              req_load, req_store;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr, req_wdata;
    logic              stall_out, load_valid, misalign_err;
    logic [31:0]       load_data, dm_wdata, dm_rdata;
    logic [ADDR_W-1:0] dm_addr;
    logic [3:0]        dm_be;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    // SPLIT_EN=0 instance
    logic              ns_load, ns_store;
    logic [2:0]        ns_funct3;
    logic [31:0]       ns_addr, ns_wdata;
    logic              ns_stall, ns_valid, ns_err;
    logic [31:0]       ns_data, ns_dm_wdata, ns_dm_rdata;
    logic [ADDR_W-1:0] ns_dm_addr;
    logic [3:0]        ns_dm_be;
    logic [31:0]       ns_mem [0:(1<<ADDR_W)-1];

    dmem_access_unit #(.ADDR_W(ADDR_W), .SPLIT_EN(1'b1)) u_dut (
        .clk(clk), .nrst(nrst), .req_load(req_load), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall_out(stall_out), .load_data(load_data), .load_valid(load_valid),
        .misalign_err(misalign_err), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata)
    );

    dmem_access_unit #(.ADDR_W(ADDR_W), .SPLIT_EN(1'b0)) u_dut_ns (
        .clk(clk), .nrst(nrst), .req_load(ns_load), .req_store(ns_store),
        .req_funct3(ns_funct3), .req_addr(ns_addr), .req_wdata(ns_wdata),
        .stall_out(ns_stall), .load_data(ns_data), .load_valid(ns_valid),
        .misalign_err(ns_err), .dm_addr(ns_dm_addr), .dm_wdata(ns_dm_wdata),
        .dm_be(ns_dm_be), .dm_rdata(ns_dm_rdata)
    );

    // BRAM models: byte-enable write, registered read (read-before-write).
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (dm_be[b])    mem[dm_addr][8*b +: 8]       <= dm_wdata[8*b +: 8];
            if (ns_dm_be[b]) ns_mem[ns_dm_addr][8*b +: 8] <= ns_dm_wdata[8*b +: 8];
        end
        dm_rdata    <= mem[dm_addr];
        ns_dm_rdata <= ns_mem[ns_dm_addr];
    end

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_load = ld; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    endtask

    // Issue one non-crossing load and check the WB result one cycle later.
    task automatic single_load(input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] exp, input string name);
        @(negedge clk); drive(1'b1, 1'b0, f3, addr, 32'h0); #1;
        n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL %s stall got %b want 0", name, stall_out); end
        @(negedge clk); idle(); #1;
        n_tests++; if (load_valid !== 1'b1) begin n_fail++; $display("FAIL %s load_valid got %b want 1", name, load_valid); end
        n_tests++; if (load_data !== exp) begin n_fail++; $display("FAIL %s load_data got %h want %h", name, load_data, exp); end
    endtask

    task automatic test_reset();
        nrst = 1'b0; idle();
        ns_load = 1'b0; ns_store = 1'b0; ns_funct3 = F3_W; ns_addr = 32'h0; ns_wdata = 32'h0;
        repeat (3) @(negedge clk);
        nrst = 1'b1; #1;
        n_tests++; if (stall_out !== 1'b0 || misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset stall/err got %b/%b want 0/0", stall_out, misalign_err); end
        n_tests++; if (load_valid !== 1'b0 || load_data !== 32'h0) begin n_fail++; $display("FAIL reset load got %b/%h want 0/0", load_valid, load_data); end
        n_tests++; if (dm_be !== 4'h0 || dm_wdata !== 32'h0 || dm_addr !== '0) begin n_fail++; $display("FAIL reset port got be=%b wd=%h a=%0d want 0", dm_be, dm_wdata, dm_addr); end
    endtask

    task automatic test_aligned_load();
        @(negedge clk); drive(1'b1, 1'b0, F3_W, 32'h000, 32'h0); #1;
        n_tests++; if (dm_addr !== 10'd0 || dm_be !== 4'h0 || stall_out !== 1'b0) begin n_fail++; $display("FAIL lw0 issue got a=%0d be=%b st=%b want 0/0/0", dm_addr, dm_be, stall_out); end
        @(negedge clk); idle(); #1;
        n_tests++; if (load_valid !== 1'b1 || load_data !== 32'h44332211) begin n_fail++; $display("FAIL lw0 result got %b/%h want 1/44332211", load_valid, load_data); end
    endtask

    task automatic test_narrow_loads();
        single_load(F3_B,  32'h007, 32'hFFFFFF88, "lb7");
        single_load(F3_BU, 32'h007, 32'h00000088, "lbu7");
        single_load(F3_H,  32'h002, 32'h00004433, "lh2");
        single_load(F3_HU, 32'h006, 32'h00008877, "lhu6");
    endtask

    task automatic test_split_load();
        @(negedge clk); drive(1'b1, 1'b0, F3_W, 32'h002, 32'h0); #1;
        n_tests++; if (dm_addr !== 10'd0 || stall_out !== 1'b1) begin n_fail++; $display("FAIL lw2 t got a=%0d st=%b want 0/1", dm_addr, stall_out); end
        n_tests++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL lw2 misalign_err got %b want 0", misalign_err); end
        @(negedge clk); idle(); #1;
        n_tests++; if (dm_addr !== 10'd1 || stall_out !== 1'b0 || load_valid !== 1'b0) begin n_fail++; $display("FAIL lw2 t+1 got a=%0d st=%b lv=%b want 1/0/0", dm_addr, stall_out, load_valid); end
        @(negedge clk); #1;
        n_tests++; if (load_valid !== 1'b1 || load_data !== 32'h66554433) begin n_fail++; $display("FAIL lw2 result got %b/%h want 1/66554433", load_valid, load_data); end
    endtask

    task automatic test_wrap();
        @(negedge clk); drive(1'b1, 1'b0, F3_W, 32'hFFE, 32'h0); #1;
        n_tests++; if (dm_addr !== 10'd1023 || stall_out !== 1'b1) begin n_fail++; $display("FAIL wrap t got a=%0d st=%b want 1023/1", dm_addr, stall_out); end
        @(negedge clk); idle(); #1;
        n_tests++; if (dm_addr !== 10'd0) begin n_fail++; $display("FAIL wrap t+1 got a=%0d want 0", dm_addr); end
        @(negedge clk); #1;
        n_tests++; if (load_valid !== 1'b1 || load_data !== 32'h2211DDCC) begin n_fail++; $display("FAIL wrap result got %b/%h want 1/2211ddcc", load_valid, load_data); end
    endtask

    task automatic test_split_store();
        @(negedge clk); drive(1'b0, 1'b1, F3_H, 32'h003, 32'h0000BEEF); #1;
        n_tests++; if (dm_addr !== 10'd0 || dm_be !== 4'b1000 || dm_wdata !== 32'hEF000000 || stall_out !== 1'b1) begin n_fail++; $display("FAIL sh3 t got a=%0d be=%b wd=%h st=%b want 0/1000/ef000000/1", dm_addr, dm_be, dm_wdata, stall_out); end
        @(negedge clk); idle(); #1;
        n_tests++; if (dm_addr !== 10'd1 || dm_be !== 4'b0001 || dm_wdata !== 32'h000000BE) begin n_fail++; $display("FAIL sh3 t+1 got a=%0d be=%b wd=%h want 1/0001/000000be", dm_addr, dm_be, dm_wdata); end
        n_tests++; if (load_valid !== 1'b0) begin n_fail++; $display("FAIL sh3 load_valid got %b want 0", load_valid); end
        single_load(F3_W, 32'h000, 32'hEF332211, "sh3 rb0");
        single_load(F3_W, 32'h004, 32'h887766BE, "sh3 rb1");
    endtask

    task automatic test_reset_mid_split();
        @(negedge clk); drive(1'b0, 1'b1, F3_W, 32'h001, 32'hA1B2C3D4); #1;
        n_tests++; if (dm_be !== 4'b1110 || dm_wdata !== 32'hB2C3D400 || stall_out !== 1'b1) begin n_fail++; $display("FAIL sw1 t got be=%b wd=%h st=%b want 1110/b2c3d400/1", dm_be, dm_wdata, stall_out); end
        @(negedge clk); idle(); nrst = 1'b0; #1;
        n_tests++; if (dm_be !== 4'h0) begin n_fail++; $display("FAIL sw1 reset be got %b want 0", dm_be); end
        @(negedge clk); nrst = 1'b1; #1;
        n_tests++; if (dm_be !== 4'h0 || stall_out !== 1'b0 || load_valid !== 1'b0 || dm_addr !== 10'd0) begin n_fail++; $display("FAIL sw1 t+2 got be=%b st=%b lv=%b a=%0d want 0/0/0/0", dm_be, stall_out, load_valid, dm_addr); end
        n_tests++; if (mem[1] !== 32'h887766BE) begin n_fail++; $display("FAIL sw1 word1 got %h want 887766be", mem[1]); end
        single_load(F3_W, 32'h000, 32'hB2C3D411, "sw1 rb0");
        single_load(F3_W, 32'h004, 32'h887766BE, "sw1 rb1");
    endtask

    task automatic test_no_split();
        @(negedge clk); ns_load = 1'b1; ns_funct3 = F3_W; ns_addr = 32'h002; #1;
        n_tests++; if (ns_err !== 1'b1 || ns_stall !== 1'b0 || ns_dm_addr !== 10'd0) begin n_fail++; $display("FAIL nosplit t got err=%b st=%b a=%0d want 1/0/0", ns_err, ns_stall, ns_dm_addr); end
        @(negedge clk); ns_load = 1'b0; ns_addr = 32'h0; #1;
        n_tests++; if (ns_err !== 1'b0) begin n_fail++; $display("FAIL nosplit err t+1 got %b want 0", ns_err); end
        n_tests++; if (ns_valid !== 1'b1 || ns_data !== 32'h00004433) begin n_fail++; $display("FAIL nosplit result got %b/%h want 1/00004433", ns_valid, ns_data); end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i] = 32'h0;
            ns_mem[i] = 32'h0;
        end
        mem[0] = 32'h44332211; mem[1] = 32'h88776655; mem[1023] = 32'hDDCCBBAA;
        ns_mem[0] = 32'h44332211; ns_mem[1] = 32'h88776655;

        test_reset();
        test_aligned_load();
        test_narrow_loads();
        test_split_load();
        test_wrap();
        test_split_store();
        test_reset_mid_split();
        test_no_split();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
